// File: rtl/decode_pipe_if.sv
// ============================================================================
// Module   : decode_pipe_if
// Brief    : Fetch-side and issue-side handshake bundle for decode_pipe.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface decode_pipe_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 2
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [31:0]       instr_i;
    logic [PC_W-1:0]   pc_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [4:0]        rs_o;
    logic [4:0]        rt_o;
    logic [4:0]        rd_o;
    logic [4:0]        shamt_o;
    logic [5:0]        op_o;
    logic [5:0]        funct_o;
    logic [25:0]       target_o;
    logic [31:0]       imm_o;
    logic [PC_W-1:0]   pc_o;
    logic              is_rtype_o;
    logic              is_branch_o;
    logic              is_jump_o;
    logic              is_load_o;
    logic              is_store_o;
    logic [4:0]        dest_o;
    logic              load_use_o;
    logic [CNT_W-1:0]  count_o;

    modport slave (
        input  in_valid_i, instr_i, pc_i, out_ready_i,
        output in_ready_o, out_valid_o, rs_o, rt_o, rd_o, shamt_o, op_o,
               funct_o, target_o, imm_o, pc_o, is_rtype_o, is_branch_o,
               is_jump_o, is_load_o, is_store_o, dest_o, load_use_o, count_o
    );

    modport master (
        output in_valid_i, instr_i, pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, rs_o, rt_o, rd_o, shamt_o, op_o,
               funct_o, target_o, imm_o, pc_o, is_rtype_o, is_branch_o,
               is_jump_o, is_load_o, is_store_o, dest_o, load_use_o, count_o
    );
endinterface

`default_nettype wire

// File: rtl/decode_pipe.sv
// ============================================================================
// Module   : decode_pipe
// Brief    : MIPS-I decode stage with a decoded-entry FIFO and flush.
//            Optional load-use tracking enabled by macro DECODE_LOAD_USE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module decode_pipe #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32
) (
    input  wire logic     clk_i,
    input  wire logic     rst_i,
    input  wire logic     flush_i,
    decode_pipe_if.slave  dp
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [5:0]      op;
        logic [25:0]     target;
        logic [31:0]     imm;
        logic [PC_W-1:0] pc;
        logic            rtype;
        logic            branch;
        logic            jump;
        logic            load;
        logic            store;
        logic [4:0]      dest;
        logic            lu;
    } entry_t;

    entry_t            r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    entry_t            w_dec;
    entry_t            w_out;
    logic              w_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_lu;
    logic [5:0]        w_funct;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;

    assign w_valid       = (r_count != '0);
    assign dp.in_ready_o = (r_count < CNT_W'(DEPTH)) & ~rst_i;
    assign w_push        = dp.in_valid_i & dp.in_ready_o & ~flush_i;
    assign w_pop         = w_valid & dp.out_ready_i & ~flush_i;

    assign w_funct = dp.instr_i[5:0];
    assign w_rs    = dp.instr_i[25:21];
    assign w_rt    = dp.instr_i[20:16];
    assign w_rd    = dp.instr_i[15:11];

    always_comb begin
        w_dec        = '0;
        w_dec.op     = dp.instr_i[31:26];
        w_dec.target = dp.instr_i[25:0];
        w_dec.pc     = dp.pc_i;
        case (w_dec.op)
            6'h0C, 6'h0D, 6'h0E: w_dec.imm = {16'b0, dp.instr_i[15:0]};
            6'h0F:               w_dec.imm = {dp.instr_i[15:0], 16'b0};
            default:             w_dec.imm = {{16{dp.instr_i[15]}}, dp.instr_i[15:0]};
        endcase
        w_dec.rtype  = (w_dec.op == 6'h00);
        w_dec.branch = w_dec.op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07};
        w_dec.jump   = (w_dec.op inside {6'h02, 6'h03}) |
                       (w_dec.rtype & (w_funct inside {6'h08, 6'h09}));
        w_dec.load   = w_dec.op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
        w_dec.store  = w_dec.op inside {6'h28, 6'h29, 6'h2B};
        if (w_dec.rtype)
            w_dec.dest = (w_funct == 6'h08) ? 5'd0 : w_rd;
        else if (w_dec.op == 6'h03)
            w_dec.dest = 5'd31;
        else if ((w_dec.op inside {[6'h08:6'h0F]}) | w_dec.load)
            w_dec.dest = w_rt;
        else
            w_dec.dest = 5'd0;
        w_dec.lu = w_lu;
    end

`ifdef DECODE_LOAD_USE_EN
    // Tracker follows the most recent push, independent of what has been popped.
    logic [4:0] r_tracker;
    logic       w_uses_rs;
    logic       w_uses_rt;

    assign w_uses_rs = ~(dp.instr_i[31:26] inside {6'h02, 6'h03, 6'h0F});
    assign w_uses_rt = dp.instr_i[31:26] inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};
    assign w_lu      = (r_tracker != 5'd0) &
                       ((w_uses_rs & (w_rs == r_tracker)) |
                        (w_uses_rt & (w_rt == r_tracker)));

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i)
            r_tracker <= 5'd0;
        else if (w_push)
            r_tracker <= w_dec.load ? w_dec.dest : 5'd0;
    end
`else
    assign w_lu = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wptr] <= w_dec;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)
                r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head fields read as zero whenever the FIFO is empty.
    always_comb begin
        w_out = '0;
        if (w_valid)
            w_out = r_mem[r_rptr];
    end

    assign dp.out_valid_o = w_valid;
    assign dp.count_o     = r_count;
    assign dp.op_o        = w_out.op;
    assign dp.target_o    = w_out.target;
    assign dp.rs_o        = w_out.target[25:21];
    assign dp.rt_o        = w_out.target[20:16];
    assign dp.rd_o        = w_out.target[15:11];
    assign dp.shamt_o     = w_out.target[10:6];
    assign dp.funct_o     = w_out.target[5:0];
    assign dp.imm_o       = w_out.imm;
    assign dp.pc_o        = w_out.pc;
    assign dp.is_rtype_o  = w_out.rtype;
    assign dp.is_branch_o = w_out.branch;
    assign dp.is_jump_o   = w_out.jump;
    assign dp.is_load_o   = w_out.load;
    assign dp.is_store_o  = w_out.store;
    assign dp.dest_o      = w_out.dest;
    assign dp.load_use_o  = w_out.lu;

endmodule

`default_nettype wire

// File: tb/tb_decode_pipe.sv
// ============================================================================
// Module   : tb_decode_pipe
// Brief    : Directed, table-driven check of decode_pipe (DEPTH=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_decode_pipe;
    localparam int DEPTH = 2;
    localparam int PC_W  = 32;
    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef DECODE_LOAD_USE_EN
    localparam bit LU_ON = 1'b1;
`else
    localparam bit LU_ON = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_i;
    logic flush_i;
    int   total = 0;
    int   bad   = 0;

    decode_pipe_if #(.PC_W(PC_W), .CNT_W(CNT_W)) dp ();

    decode_pipe #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .dp      (dp)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [4:0]  dest;
        logic [4:0]  cls;   // {rtype, branch, jump, load, store}
        logic        lu;
    } vec_t;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_hold(input logic [31:0] ins, input logic [31:0] pc);
        dp.in_valid_i = 1'b1;
        dp.instr_i    = ins;
        dp.pc_i       = pc;
        tick();
        dp.in_valid_i = 1'b0;
    endtask

    task automatic pop_one();
        dp.out_ready_i = 1'b1;
        tick();
        dp.out_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        vecs[0]  = '{32'h2409FFFF, 32'hFFFFFFFF, 5'd9,  5'b00000, 1'b0}; // addiu
        vecs[1]  = '{32'h3409FFFF, 32'h0000FFFF, 5'd9,  5'b00000, 1'b0}; // ori
        vecs[2]  = '{32'h3C091234, 32'h12340000, 5'd9,  5'b00000, 1'b0}; // lui
        vecs[3]  = '{32'h0C000010, 32'h00000010, 5'd31, 5'b00100, 1'b0}; // jal
        vecs[4]  = '{32'h03E00008, 32'h00000008, 5'd0,  5'b10100, 1'b0}; // jr
        vecs[5]  = '{32'h8C880000, 32'h00000000, 5'd8,  5'b00010, 1'b0}; // lw $t0
        vecs[6]  = '{32'h010A4820, 32'h00004820, 5'd9,  5'b10000, 1'b1}; // add uses $t0
        vecs[7]  = '{32'hAC880004, 32'h00000004, 5'd0,  5'b00001, 1'b0}; // sw
        vecs[8]  = '{32'h1109FFFE, 32'hFFFFFFFE, 5'd0,  5'b01000, 1'b0}; // beq
        vecs[9]  = '{32'h08000040, 32'h00000040, 5'd0,  5'b00100, 1'b0}; // j
        vecs[10] = '{32'h3009F000, 32'h0000F000, 5'd9,  5'b00000, 1'b0}; // andi
        vecs[11] = '{32'hFC00FFFF, 32'hFFFFFFFF, 5'd0,  5'b00000, 1'b0}; // undefined op
        vecs[12] = '{32'h00000000, 32'h00000000, 5'd0,  5'b10000, 1'b0}; // nop

        rst_i = 1'b1; flush_i = 1'b0;
        dp.in_valid_i = 1'b0; dp.out_ready_i = 1'b0;
        dp.instr_i = '0; dp.pc_i = '0;
        tick(); tick();
        chk("rst_in_ready", dp.in_ready_o, 0);
        chk("rst_out_valid", dp.out_valid_o, 0);
        chk("rst_count", dp.count_o, 0);
        chk("rst_imm_gated", dp.imm_o, 0);
        rst_i = 1'b0;
        #1;
        chk("post_rst_in_ready", dp.in_ready_o, 1);

        for (int i = 0; i < 13; i++) begin
            logic [31:0] pc;
            logic [31:0] ins;
            pc  = 32'h100 + 32'(i) * 4;
            ins = vecs[i].instr;
            push_hold(ins, pc);
            chk("v_valid", dp.out_valid_o, 1);
            chk("v_count", dp.count_o, 1);
            chk("v_pc", dp.pc_o, pc);
            chk("v_imm", dp.imm_o, vecs[i].imm);
            chk("v_dest", dp.dest_o, vecs[i].dest);
            chk("v_class", {dp.is_rtype_o, dp.is_branch_o, dp.is_jump_o,
                            dp.is_load_o, dp.is_store_o}, vecs[i].cls);
            chk("v_op", dp.op_o, ins[31:26]);
            chk("v_target", dp.target_o, ins[25:0]);
            chk("v_rs", dp.rs_o, ins[25:21]);
            chk("v_rt", dp.rt_o, ins[20:16]);
            chk("v_rd", dp.rd_o, ins[15:11]);
            chk("v_shamt", dp.shamt_o, ins[10:6]);
            chk("v_funct", dp.funct_o, ins[5:0]);
            chk("v_load_use", dp.load_use_o, vecs[i].lu & LU_ON);
            pop_one();
            chk("v_drained", dp.count_o, 0);
        end

        // lw, nop, add: the intervening nop clears the hazard.
        push_hold(32'h8C880000, 32'h400);
        pop_one();
        push_hold(32'h00000000, 32'h404);
        pop_one();
        push_hold(32'h010A4820, 32'h408);
        chk("lu_nop_between", dp.load_use_o, 0);
        pop_one();

        // Fill past capacity with consumer stalled.
        dp.in_valid_i = 1'b1; dp.instr_i = 32'h24010001; dp.pc_i = 32'h500;
        tick();
        dp.instr_i = 32'h24020002; dp.pc_i = 32'h504;
        tick();
        chk("full_count", dp.count_o, 2);
        chk("full_in_ready", dp.in_ready_o, 0);
        dp.instr_i = 32'h24030003; dp.pc_i = 32'h508;
        tick();
        chk("held_count", dp.count_o, 2);
        chk("held_head_pc", dp.pc_o, 32'h500);
        dp.out_ready_i = 1'b1;
        tick();
        dp.out_ready_i = 1'b0;
        chk("pop_when_full_count", dp.count_o, 1);
        chk("pop_when_full_ready", dp.in_ready_o, 1);
        chk("head_after_pop", dp.pc_o, 32'h504);
        tick();
        dp.in_valid_i = 1'b0;
        chk("third_accepted", dp.count_o, 2);
        pop_one();
        chk("wrap_head_pc", dp.pc_o, 32'h508);
        chk("wrap_head_imm", dp.imm_o, 32'h3);
        // Simultaneous push and pop at count 1.
        dp.in_valid_i = 1'b1; dp.instr_i = 32'h24040004; dp.pc_i = 32'h50C;
        dp.out_ready_i = 1'b1;
        tick();
        dp.in_valid_i = 1'b0; dp.out_ready_i = 1'b0;
        chk("pushpop_count", dp.count_o, 1);
        chk("pushpop_head", dp.pc_o, 32'h50C);
        pop_one();

        // Flush with same-cycle input and pop request.
        push_hold(32'h24050005, 32'h600);
        push_hold(32'h24060006, 32'h604);
        dp.in_valid_i = 1'b1; dp.instr_i = 32'h2407AAAA; dp.pc_i = 32'h608;
        dp.out_ready_i = 1'b1; flush_i = 1'b1;
        tick();
        flush_i = 1'b0; dp.in_valid_i = 1'b0; dp.out_ready_i = 1'b0;
        chk("flush_count", dp.count_o, 0);
        chk("flush_valid", dp.out_valid_o, 0);
        chk("flush_pc_gated", dp.pc_o, 0);
        tick();
        chk("flush_dropped", dp.count_o, 0);
        push_hold(32'h24080005, 32'h700);
        chk("post_flush_pc", dp.pc_o, 32'h700);
        chk("post_flush_imm", dp.imm_o, 32'h5);
        chk("post_flush_count", dp.count_o, 1);
        pop_one();

        // Tracker cleared by flush: lw, flush, add gives no hazard.
        push_hold(32'h8C880000, 32'h800);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        push_hold(32'h010A4820, 32'h804);
        chk("lu_after_flush", dp.load_use_o, 0);
        chk("lu_after_flush_pc", dp.pc_o, 32'h804);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
Registered, flow-controlled MIPS-I instruction decode stage between fetch and register-read/issue. Accepts one instruction plus PC per cycle over valid/ready and extracts all fields. Derives sign/zero extension, instruction class and destination register internally from the opcode. Buffers decoded entries in a parametrised FIFO so fetch can run ahead of a stalled issue stage; supports a pipeline flush.

Parameters:
DEPTH, 2, decoded-entry FIFO depth; power of two, >=2
PC_W, 32, width of PC carried alongside each instruction
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
flush_i  in  1  discard all buffered entries and the same-cycle input
in_valid_i  in  1  instruction/pc valid
in_ready_o  out  1  stage can accept; = (count < DEPTH) & !rst_i
instr_i  in  32  raw instruction
pc_i  in  PC_W  instruction PC
out_valid_o  out  1  head entry valid (count != 0)
out_ready_i  in  1  consumer takes head entry
rs_o / rt_o / rd_o  out  5 each  instr[25:21] / [20:16] / [15:11]
shamt_o  out  5  instr[10:6]
op_o / funct_o  out  6 each  instr[31:26] / [5:0]
target_o  out  26  instr[25:0]
imm_o  out  32  extended immediate (see Behaviour)
pc_o  out  PC_W  PC of head entry
is_rtype_o / is_branch_o / is_jump_o / is_load_o / is_store_o  out  1 each  class flags
dest_o  out  5  architectural destination register, 0 if none
load_use_o  out  1  load-use hazard flag of head entry (optional feature)
count_o  out  CNT_W  current occupancy

Behaviour:
- Reset (rst_i=1 at an edge): count=0, read/write pointers=0, hazard tracker cleared; out_valid_o=0, in_ready_o=0 while rst_i high, 1 the cycle after. Head-field outputs are 0 while count=0 (storage contents irrelevant, outputs gated).
- Push when in_valid_i & in_ready_o & !flush_i; pop when out_valid_o & out_ready_i & !flush_i. Decode is done on push; FIFO stores decoded fields, not raw instr.
- Latency: instruction accepted at edge N visible on outputs after edge N (out_valid_o high in cycle N+1). No combinational input-to-output path.
- in_ready_o depends only on count (not on out_ready_i): when full, simultaneous pop does not enable a push that cycle.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- flush_i: at the edge count=0, pointers=0, hazard tracker cleared; same-cycle input dropped, same-cycle pop not counted. flush_i has no effect while rst_i high (reset dominates).
- Immediate: op 0x0C/0x0D/0x0E (andi/ori/xori) -> {16'b0,instr[15:0]}; op 0x0F (lui) -> {instr[15:0],16'b0}; all others -> {{16{instr[15]}},instr[15:0]}.
- Classes: is_rtype = op==0x00. is_branch = op in {0x01,0x04,0x05,0x06,0x07}. is_jump = op in {0x02,0x03} or (op==0 & funct in {0x08,0x09}). is_load = op in {0x20,0x21,0x23,0x24,0x25}. is_store = op in {0x28,0x29,0x2B}.
- dest: R-type except jr (funct 0x08) -> rd; jr -> 0; jal (0x03) -> 31; I-type ALU (0x08-0x0F) and loads -> rt; stores, branches, j, undefined opcodes -> 0.

Optional Feature:
Macro DECODE_LOAD_USE_EN.
- Defined: tracker holds dest of most recently pushed entry if it was a load with dest!=0, else 0. Incoming entry flagged load_use=1 if tracker!=0 and (uses_rs & rs==tracker, or uses_rt & rt==tracker). uses_rs: all ops except 0x02, 0x03, 0x0F. uses_rt: R-type, 0x04, 0x05, stores. Flag stored per entry, output as load_use_o. Tracker updated on every push, cleared by reset/flush; unchanged on idle cycles.
- Undefined: no tracker logic; load_use_o tied 0.

Test Plan:
- Reset then push addiu $t1,$zero,-1 (0x2409FFFF) pc=0x100 -> next cycle out_valid_o=1, imm_o=0xFFFFFFFF, dest_o=9, pc_o=0x100, count_o=1.
- Push ori 0x3409FFFF, lui 0x3C091234 -> imm_o 0x0000FFFF then 0x12340000; dest_o=9 both.
- out_ready_i=0, push 3 instrs with DEPTH=2 -> third held off (in_ready_o=0 at count 2); out_ready_i=1 one cycle -> count 1, in_ready_o=1 next cycle, order preserved across pointer wrap.
- jal 0x0C000010 -> is_jump=1, dest_o=31, target_o=0x0000010; jr $ra 0x03E00008 -> is_jump=1, is_rtype=1, dest_o=0.
- Fill to 2 entries, assert flush_i with in_valid_i=1 -> count_o=0, out_valid_o=0 next cycle, flushed-cycle instr never appears.
- DECODE_LOAD_USE_EN: push lw $t0,0($a0) (0x8C880000) then add $t1,$t0,$t2 (0x010A4820) -> second entry load_use_o=1; with nop between -> 0; macro undefined -> always 0.
